instr_mem_sync: RTL and testbench
=================================

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter NOP_WORD, default 32'h0000_0000, word returned on faulting fetch.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, fetch request present.
REQ-008 SHALL have port req_ready, output, 1, fetch request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_addr, input, ADDR_W, fetch byte address.
REQ-010 SHALL have port rsp_valid, output, 1, response held in output register.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes response.
REQ-012 SHALL have port rsp_instr, output, DATA_W, fetched instruction.
REQ-013 SHALL have port rsp_fault, output, 2, fault code (00 ok, 01 misaligned, 10 out-of-range, 11 both).
REQ-014 SHALL have port flush, input, 1, discard held/in-flight response (branch/jump redirect).
REQ-015 SHALL have port wr_en, input, 1, program-load write strobe.
REQ-016 SHALL have port wr_addr, input, ADDR_W, program-load byte address.
REQ-017 SHALL have port wr_data, input, DATA_W, program-load word.
REQ-018 SHALL have port wr_err, output, 1, one-cycle pulse: last write rejected.

Function
REQ-019 SHALL compute word index = req_addr >> log2(DATA_W/8); misaligned when low log2(DATA_W/8) bits nonzero; out-of-range when index >= DEPTH.
REQ-020 SHALL assert req_ready = !flush && (!rsp_valid || rsp_ready), combinationally.
REQ-021 SHALL, on accept (req_valid && req_ready), present the response exactly one cycle later: rsp_valid=1, rsp_instr=mem[index], rsp_fault=00.
REQ-022 SHALL, on a faulting accept, return rsp_instr=NOP_WORD with the corresponding rsp_fault code; memory not read.
REQ-023 SHALL hold rsp_instr, rsp_fault, rsp_valid stable while rsp_valid && !rsp_ready.
REQ-024 SHALL clear rsp_valid next cycle when rsp_ready is high and no new accept occurs; back-to-back accepts sustain one response per cycle.
REQ-025 SHALL, on flush, clear rsp_valid next cycle regardless of rsp_ready; no request is accepted in a flush cycle.
REQ-026 SHALL write wr_data to mem[wr index] on rising edge when wr_en and the write address is aligned and in range.
REQ-027 SHALL reject misaligned or out-of-range writes, leave memory unchanged, and pulse wr_err the following cycle.
REQ-028 SHALL, when a write and an accepted fetch target the same word in the same cycle, return the new wr_data (write-first).
REQ-029 SHALL keep rsp_instr unchanged (last value) when rsp_valid is low.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, set rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=00, wr_err=0.
REQ-031 SHALL force req_ready=0 and ignore wr_en while rst_n=0.
REQ-032 SHALL NOT reset memory contents; an outstanding response is discarded by reset mid-operation.

Structure
REQ-033 SHALL take fault-code constants (FAULT_OK, FAULT_MISALIGN, FAULT_OOR) and NOP_WORD default from shared package instr_mem_pkg.
REQ-034 SHALL place storage in one sub-module instr_mem_array (1 write port, 1 synchronous read port, write-first); control and handshake stay in instr_mem_sync.

Verification
REQ-035 SHALL cover: load words 0x20420020 at byte 0 and 0x8C010004 at byte 4, fetch 0 then 4 back-to-back with rsp_ready=1 -> responses on consecutive cycles, fault 00, exact words.
REQ-036 SHALL cover: fetch byte 2 -> rsp_instr=NOP_WORD, rsp_fault=01; fetch byte 4*DEPTH -> NOP_WORD, rsp_fault=10.
REQ-037 SHALL cover: accept fetch, hold rsp_ready=0 for 3 cycles -> req_ready=0, response stable 3 cycles, released on rsp_ready=1.
REQ-038 SHALL cover: response held and flush=1 with req_valid=1 -> rsp_valid=0 next cycle, no request accepted that cycle.
REQ-039 SHALL cover: same-cycle write 0xDEADBEEF and fetch of byte 8 -> rsp_instr=0xDEADBEEF; write to byte 3 -> wr_err pulse, memory unchanged.
REQ-040 SHALL cover: rst_n=0 while response held -> rsp_valid=0, rsp_instr=NOP_WORD next cycle; previously loaded words still readable after reset.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and sizing helpers for the instruction memory
package instr_mem_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_OOR      = 2'b10;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Number of byte-offset bits inside one instruction word.
    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// rtl/instr_mem_sync_if.sv - fetch, response, flush and program-load signals of the instruction memory
interface instr_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [1:0]        rsp_fault;
    logic              flush;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, wr_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, wr_err
    );

endinterface

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - word storage with one write port and one registered write-first read port
module instr_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous instruction memory with fetch handshake, fault codes and flush
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_mem_sync_if.slave bus
);

    localparam int OFF_W = off_bits(DATA_W);
    localparam int IDX_W = idx_bits(DEPTH);

    function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word_idx;
        logic [1:0]        code;
        word_idx = addr >> OFF_W;
        code     = FAULT_OK;
        if (addr[OFF_W-1:0] != '0) begin
            code = code | FAULT_MISALIGN;
        end
        if (word_idx >= ADDR_W'(DEPTH)) begin
            code = code | FAULT_OOR;
        end
        return code;
    endfunction

    logic              rsp_valid_q;
    logic [1:0]        rsp_fault_q;
    logic              rsp_from_mem_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] rd_data;

    logic [1:0]        req_fault;
    logic [1:0]        wr_fault;
    logic              req_ready;
    logic              accept;
    logic              rd_en;
    logic              wr_ok;
    logic              wr_bad;

    always_comb begin
        req_fault = addr_fault(bus.req_addr);
        wr_fault  = addr_fault(bus.wr_addr);
        req_ready = rst_n && !bus.flush && (!rsp_valid_q || bus.rsp_ready);
        accept    = bus.req_valid && req_ready;
        rd_en     = accept && (req_fault == FAULT_OK);
        wr_ok     = rst_n && bus.wr_en && (wr_fault == FAULT_OK);
        wr_bad    = rst_n && bus.wr_en && (wr_fault != FAULT_OK);
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_idx  (bus.wr_addr[OFF_W +: IDX_W]),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_idx  (bus.req_addr[OFF_W +: IDX_W]),
        .rd_data (rd_data)
    );

    // The array's read register holds the fetched word; faulting fetches select NOP_WORD instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_fault_q    <= FAULT_OK;
            rsp_from_mem_q <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
            if (accept) begin
                rsp_valid_q    <= 1'b1;
                rsp_fault_q    <= req_fault;
                rsp_from_mem_q <= (req_fault == FAULT_OK);
            end else if (bus.flush || bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_instr = rsp_from_mem_q ? rd_data : NOP_WORD;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - self-checking bench for instr_mem_sync
module tb_instr_mem_sync;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mm [DEPTH];

    always #5 clk = ~clk;

    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    instr_mem_sync #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .NOP_WORD (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_fault_of(input logic [31:0] a);
        return {((a / 4) >= DEPTH), ((a % 4) != 0)};
    endfunction

    function automatic logic [31:0] exp_instr_of(input logic [31:0] a);
        if (exp_fault_of(a) != 2'b00) return NOP;
        return mm[int'(a / 4)];
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        if (exp_fault_of(a) == 2'b00) mm[int'(a / 4)] = d;
    endtask

    task automatic idle();
        bus.req_valid = 0; bus.req_addr = 0; bus.rsp_ready = 1; bus.flush = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        model_wr(a, d);
        tick();
        bus.wr_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.req_valid = 1; bus.req_addr = 0; bus.rsp_ready = 1;
        bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b exp 0", bus.req_ready); end
        tick(); tick();
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== NOP) begin bad++; $display("FAIL rst_instr: got %h exp %h", bus.rsp_instr, NOP); end
        total++; if (bus.rsp_fault !== 2'b00) begin bad++; $display("FAIL rst_fault: got %b exp 00", bus.rsp_fault); end
        total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err: got %b exp 0", bus.wr_err); end
        idle();
        rst_n = 1;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b exp 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_load_fetch();
        do_write(32'd0, 32'h2042_0020);
        do_write(32'd4, 32'h8C01_0004);
        bus.req_valid = 1; bus.req_addr = 0; bus.rsp_ready = 1;
        tick();
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL lf_valid0: got %b exp 1", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== 32'h2042_0020) begin bad++; $display("FAIL lf_instr0: got %h exp 20420020", bus.rsp_instr); end
        total++; if (bus.rsp_fault !== 2'b00) begin bad++; $display("FAIL lf_fault0: got %b exp 00", bus.rsp_fault); end
        bus.req_addr = 4;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL lf_ready_b2b: got %b exp 1", bus.req_ready); end
        tick();
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL lf_valid1: got %b exp 1", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== 32'h8C01_0004) begin bad++; $display("FAIL lf_instr1: got %h exp 8c010004", bus.rsp_instr); end
        bus.req_valid = 0;
        tick();
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL lf_drain: got %b exp 0", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== 32'h8C01_0004) begin bad++; $display("FAIL lf_hold_idle: got %h exp 8c010004", bus.rsp_instr); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        addrs[0] = 32'd2; addrs[1] = 4 * DEPTH; addrs[2] = 4 * DEPTH + 1;
        bus.req_valid = 1; bus.rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = addrs[i];
            tick();
            total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL flt_valid[%0d]: got %b exp 1", i, bus.rsp_valid); end
            total++; if (bus.rsp_instr !== NOP) begin bad++; $display("FAIL flt_instr[%0d]: got %h exp %h", i, bus.rsp_instr, NOP); end
            total++; if (bus.rsp_fault !== exp_fault_of(addrs[i])) begin bad++; $display("FAIL flt_code[%0d]: got %b exp %b", i, bus.rsp_fault, exp_fault_of(addrs[i])); end
        end
        bus.req_valid = 0;
        tick();
    endtask

    task automatic test_stall();
        bus.req_valid = 1; bus.req_addr = 4; bus.rsp_ready = 0;
        tick();
        bus.req_addr = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b exp 0", i, bus.req_ready); end
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h8C01_0004 || bus.rsp_fault !== 2'b00) begin
                bad++; $display("FAIL stall_hold[%0d]: got %b/%h/%b exp 1/8c010004/00", i, bus.rsp_valid, bus.rsp_instr, bus.rsp_fault);
            end
            tick();
        end
        bus.req_valid = 0; bus.rsp_ready = 1;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b exp 1", bus.req_ready); end
        tick();
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got %b exp 0", bus.rsp_valid); end
    endtask

    task automatic test_flush();
        bus.req_valid = 1; bus.req_addr = 0; bus.rsp_ready = 0;
        tick();
        bus.flush = 1; bus.req_addr = 4;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b exp 0", bus.req_ready); end
        tick();
        bus.flush = 0; bus.req_valid = 0;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b exp 0", bus.rsp_valid); end
        tick();
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept: got %b exp 0", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== 32'h2042_0020) begin bad++; $display("FAIL flush_hold_instr: got %h exp 20420020", bus.rsp_instr); end
        bus.rsp_ready = 1;
    endtask

    task automatic test_write_first();
        bus.wr_en = 1; bus.wr_addr = 8; bus.wr_data = 32'hDEAD_BEEF;
        model_wr(32'd8, 32'hDEAD_BEEF);
        bus.req_valid = 1; bus.req_addr = 8; bus.rsp_ready = 1;
        tick();
        bus.req_valid = 0; bus.wr_en = 0;
        total++; if (bus.rsp_instr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wf_instr: got %h exp deadbeef", bus.rsp_instr); end
        total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL wf_no_err: got %b exp 0", bus.wr_err); end
        bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 32'h1234_5678;
        tick();
        bus.wr_en = 0;
        total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL wf_err_mis: got %b exp 1", bus.wr_err); end
        tick();
        total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL wf_err_pulse: got %b exp 0", bus.wr_err); end
        bus.wr_en = 1; bus.wr_addr = 4 * DEPTH; bus.wr_data = 32'h1234_5678;
        tick();
        bus.wr_en = 0;
        total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL wf_err_oor: got %b exp 1", bus.wr_err); end
        bus.req_valid = 1; bus.req_addr = 0;
        tick();
        bus.req_valid = 0;
        total++; if (bus.rsp_instr !== exp_instr_of(32'd0)) begin bad++; $display("FAIL wf_mem_kept: got %h exp %h", bus.rsp_instr, exp_instr_of(32'd0)); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1; bus.req_addr = 8; bus.rsp_ready = 0;
        tick();
        bus.req_valid = 0;
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_held: got %b exp 1", bus.rsp_valid); end
        rst_n = 0;
        bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 32'h1111_1111;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b exp 0", bus.req_ready); end
        tick();
        bus.wr_en = 0; rst_n = 1; bus.rsp_ready = 1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b exp 0", bus.rsp_valid); end
        total++; if (bus.rsp_instr !== NOP) begin bad++; $display("FAIL rm_instr: got %h exp %h", bus.rsp_instr, NOP); end
        bus.req_valid = 1; bus.req_addr = 0;
        tick();
        total++; if (bus.rsp_instr !== 32'h2042_0020) begin bad++; $display("FAIL rm_kept0: got %h exp 20420020", bus.rsp_instr); end
        bus.req_addr = 8;
        tick();
        bus.req_valid = 0;
        total++; if (bus.rsp_instr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rm_kept8: got %h exp deadbeef", bus.rsp_instr); end
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, DEPTH - 1) * 4);
        return 32'($urandom_range(0, 4 * DEPTH + 15));
    endfunction

    task automatic test_random();
        logic        ev, have, ee, er, acc, fl, rr, rv, we;
        logic [31:0] ei, ra, wa, wd;
        logic [1:0]  ef;
        for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), $urandom);
        ev = 0; have = 0; ee = 0; ei = 0; ef = 0;
        for (int c = 0; c < 400; c++) begin
            total++; if (bus.rsp_valid !== ev) begin bad++; $display("FAIL rnd_valid@%0d: got %b exp %b", c, bus.rsp_valid, ev); end
            if (have) begin
                total++; if (bus.rsp_instr !== ei) begin bad++; $display("FAIL rnd_instr@%0d: got %h exp %h", c, bus.rsp_instr, ei); end
            end
            if (ev) begin
                total++; if (bus.rsp_fault !== ef) begin bad++; $display("FAIL rnd_fault@%0d: got %b exp %b", c, bus.rsp_fault, ef); end
            end
            total++; if (bus.wr_err !== ee) begin bad++; $display("FAIL rnd_wr_err@%0d: got %b exp %b", c, bus.wr_err, ee); end
            rv = 1'($urandom_range(0, 1)); ra = rand_addr();
            rr = ($urandom_range(0, 3) != 0); fl = ($urandom_range(0, 7) == 0);
            we = ($urandom_range(0, 3) == 0); wa = rand_addr(); wd = $urandom;
            bus.req_valid = rv; bus.req_addr = ra; bus.rsp_ready = rr; bus.flush = fl;
            bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
            #1;
            acc = rv && !fl && (!ev || rr);
            total++; if (bus.req_ready !== (!fl && (!ev || rr))) begin bad++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, bus.req_ready, !fl && (!ev || rr)); end
            ee = we && (exp_fault_of(wa) != 2'b00);
            if (we) model_wr(wa, wd);
            if (acc) begin
                ev = 1; have = 1; ei = exp_instr_of(ra); ef = exp_fault_of(ra);
            end else if (fl || rr) begin
                ev = 0;
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick();
        test_reset();
        test_load_fetch();
        test_faults();
        test_stall();
        test_flush();
        test_write_first();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
